// File: rtl/multicycle_control_unit.sv
// Main controller FSM for the multicycle RV32I core: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath strobe, select and ALU op.
module multicycle_control_unit #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_adr_src,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic [1:0]  o_result_src,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [2:0]  o_imm_src,
  output logic [3:0]  o_alu_control,
  output logic        o_illegal,
  output logic [3:0]  o_state
);

  // LUI and AUIPC share S_UPPER (they differ only in source A) so the FSM fits 4 bits
  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_UPPER, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b0011;

  state_t      r_state;
  state_t      w_next;
  state_t      w_dec_next;
  logic        w_dec_ok;
  logic [2:0]  w_imm_src;
  logic [3:0]  w_alu_op;
  logic [3:0]  w_branch_op;
  logic        w_taken;
  logic        w_ready;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_ready  = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
  assign w_unused = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};
  assign o_state  = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_BOOT;
    else          r_state <= w_next;
  end

  // Opcode decode: DECODE successor, legality of funct3 and immediate format
  always_comb begin
    w_dec_next = S_FETCH;
    w_dec_ok   = 1'b1;
    w_imm_src  = 3'b000;
    case (w_opcode)
      OP_LOAD:   begin w_dec_next = S_MEMADR;
                       w_dec_ok = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11); end
      OP_STORE:  begin w_dec_next = S_MEMADR; w_imm_src = 3'b001;
                       w_dec_ok = !w_funct3[2] && (w_funct3[1:0] != 2'b11); end
      OP_R:      w_dec_next = S_EXECR;
      OP_I:      w_dec_next = S_EXECI;
      OP_BRANCH: begin w_dec_next = S_BRANCH; w_imm_src = 3'b010;
                       w_dec_ok = (w_funct3[2:1] != 2'b01); end
      OP_JAL:    begin w_dec_next = S_JAL; w_imm_src = 3'b011; end
      OP_JALR:   begin w_dec_next = S_JALR; w_dec_ok = (w_funct3 == 3'b000); end
      OP_LUI,
      OP_AUIPC:  begin w_dec_next = S_UPPER; w_imm_src = 3'b100; end
      default:   w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000: w_alu_op = (r_state == S_EXECR && i_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_op = ALU_SLL;
      3'b010: w_alu_op = ALU_SLT;
      3'b011: w_alu_op = ALU_SLTU;
      3'b100: w_alu_op = ALU_XOR;
      3'b101: w_alu_op = i_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_op = ALU_OR;
      3'b111: w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  // Equality branches test zero of SUB; ordered branches test zero of SLT/SLTU (zero = not less)
  assign w_branch_op = !w_funct3[2] ? ALU_SUB : (w_funct3[1] ? ALU_SLTU : ALU_SLT);
  assign w_taken     = w_funct3[2] ? (i_zero == w_funct3[0]) : (i_zero ^ w_funct3[0]);

  always_comb begin
    w_next        = r_state;
    o_pc_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_result_src  = 2'b00;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_imm_src     = 3'b000;
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read = 1'b1; o_alu_src_b = 2'b10; o_result_src = 2'b10;
        if (w_ready) begin
          o_ir_write = 1'b1; o_pc_write = 1'b1; w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01; o_alu_src_b = 2'b01; o_imm_src = w_imm_src;
        w_next = w_dec_ok ? w_dec_next : (TRAP_ON_ILLEGAL ? S_HALT : S_FETCH);
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; o_imm_src = w_imm_src;
        w_next = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1; o_mem_read = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = 2'b01; o_reg_write = 1'b1; w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adr_src = 1'b1; o_mem_write = 1'b1;
        if (w_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10; o_alu_control = w_alu_op; w_next = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; o_imm_src = w_imm_src;
        o_alu_control = w_alu_op; w_next = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1; w_next = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a = 2'b10; o_alu_control = w_branch_op; o_pc_write = w_taken;
        w_next = S_FETCH;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01; o_alu_src_b = 2'b10; o_pc_write = 1'b1; w_next = S_ALUWB;
      end
      S_JALR: begin
        o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; o_imm_src = w_imm_src;
        o_result_src = 2'b10; o_pc_write = 1'b1; w_next = S_JALRLINK;
      end
      S_JALRLINK: begin
        o_alu_src_a = 2'b01; o_alu_src_b = 2'b10; w_next = S_ALUWB;
      end
      S_UPPER: begin
        o_alu_src_a = w_opcode[5] ? 2'b11 : 2'b01; o_alu_src_b = 2'b01;
        o_imm_src = w_imm_src; w_next = S_ALUWB;
      end
      S_HALT: o_illegal = 1'b1;
      default: w_next = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: an instruction-level model queues the expected
// control vector of every cycle and a negedge monitor compares it with the DUT outputs.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } ctrlT;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b0011;

  logic        clk = 1'b0;
  logic        rstN, rstN2;
  logic [31:0] instr, instr2;
  logic        zero, zero2, memReady, memReady2;
  logic        pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite, illegal;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB;
  logic [2:0]  immSrc;
  logic [3:0]  aluControl, state;
  logic        pcWrite2, adrSrc2, memRead2, memWrite2, irWrite2, regWrite2, illegal2;
  logic [1:0]  resultSrc2, aluSrcA2, aluSrcB2;
  logic [2:0]  immSrc2;
  logic [3:0]  aluControl2, state2;
  ctrlT        act1, act2;

  ctrlT  expQ[$];
  bit    careQ[$];
  string nameQ[$];
  ctrlT  expQ2[$];
  bit    careQ2[$];
  string nameQ2[$];
  ctrlT  monExp;
  bit    monCare;
  string monName;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .i_clk(clk), .i_rst_n(rstN), .i_instr(instr), .i_zero(zero), .i_mem_ready(memReady),
    .o_pc_write(pcWrite), .o_adr_src(adrSrc), .o_mem_read(memRead), .o_mem_write(memWrite),
    .o_ir_write(irWrite), .o_reg_write(regWrite), .o_result_src(resultSrc),
    .o_alu_src_a(aluSrcA), .o_alu_src_b(aluSrcB), .o_imm_src(immSrc),
    .o_alu_control(aluControl), .o_illegal(illegal), .o_state(state)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dutNoTrap (
    .i_clk(clk), .i_rst_n(rstN2), .i_instr(instr2), .i_zero(zero2), .i_mem_ready(memReady2),
    .o_pc_write(pcWrite2), .o_adr_src(adrSrc2), .o_mem_read(memRead2), .o_mem_write(memWrite2),
    .o_ir_write(irWrite2), .o_reg_write(regWrite2), .o_result_src(resultSrc2),
    .o_alu_src_a(aluSrcA2), .o_alu_src_b(aluSrcB2), .o_imm_src(immSrc2),
    .o_alu_control(aluControl2), .o_illegal(illegal2), .o_state(state2)
  );

  assign act1 = {pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite, resultSrc,
                 aluSrcA, aluSrcB, immSrc, aluControl, illegal};
  assign act2 = {pcWrite2, adrSrc2, memRead2, memWrite2, irWrite2, regWrite2, resultSrc2,
                 aluSrcA2, aluSrcB2, immSrc2, aluControl2, illegal2};

  function automatic ctrlT idle();
    ctrlT c;
    c = '0;
    c.alu = ALU_ADD;
    return c;
  endfunction

  // Compare a whole control vector; the immediate format only matters where it is asked for
  task automatic checkOutput(input ctrlT act, input ctrlT exp, input bit immCare, input string name);
    logic [19:0] a, e, m;
    ctrlT mk;
    mk = '1;
    if (!immCare) mk.imm = 3'b000;
    a = act; e = exp; m = mk;
    checks++;
    if (((a ^ e) & m) !== 20'h0) begin
      errors++;
      $display("[TB] FAIL %s: got %05h expected %05h", name, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front(); monCare = careQ.pop_front(); monName = nameQ.pop_front();
      checkOutput(act1, monExp, monCare, monName);
    end
    if (expQ2.size() > 0) begin
      monExp = expQ2.pop_front(); monCare = careQ2.pop_front(); monName = nameQ2.pop_front();
      checkOutput(act2, monExp, monCare, {"notrap-", monName});
    end
  end

  // Queue the expectation for the cycle now in progress, then advance to just after the next edge
  task automatic applyStimulus(input ctrlT e, input bit immCare, input string name, input bit second);
    if (second) begin
      expQ2.push_back(e); careQ2.push_back(immCare); nameQ2.push_back(name);
    end else begin
      expQ.push_back(e); careQ.push_back(immCare); nameQ.push_back(name);
    end
    @(posedge clk); #1;
  endtask

  task automatic jitter();
    zero = 1'($urandom % 2);
    memReady = 1'($urandom % 2);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    applyStimulus(idle(), 1'b1, "reset-assert", 1'b0);
    applyStimulus(idle(), 1'b1, "reset-hold", 1'b0);
    rstN = 1'b1;
    applyStimulus(idle(), 1'b1, "boot", 1'b0);
  endtask

  function automatic int pickWaits();
    if ($urandom % 3 == 0) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  function automatic bit legalInstr(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0000011: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'b0100011: return f3 inside {3'd0, 3'd1, 3'd2};
      7'b1100011: return !(f3 inside {3'd2, 3'd3});
      7'b1100111: return f3 == 3'd0;
      7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] immKind(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] aluOp(input logic [2:0] f3, input bit b30, input bit isR);
    case (f3)
      3'd0: return (isR && b30) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return b30 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  task automatic writeBack();
    ctrlT e;
    jitter();
    e = idle(); e.rw = 1'b1;
    applyStimulus(e, 1'b0, "alu-wb", 1'b0);
  endtask

  // Memory wait loop: request held until the cycle in which mem_ready is seen
  task automatic memAccess(input bit isWrite, input int waits);
    ctrlT e;
    for (int k = 0; k <= waits; k++) begin
      zero = 1'($urandom % 2);
      memReady = (k == waits);
      e = idle(); e.adr = 1'b1;
      if (isWrite) e.mw = 1'b1; else e.mr = 1'b1;
      applyStimulus(e, 1'b0, isWrite ? "mem-write" : "mem-read", 1'b0);
    end
  endtask

  task automatic runInstr(input logic [31:0] ins, input int memWaits, input int forceZero,
                          input bit resetInStore);
    logic [6:0] op;
    logic [2:0] f3;
    bit         b30, equal, less, cond;
    int         n;
    ctrlT       e;
    op = ins[6:0]; f3 = ins[14:12]; b30 = ins[30];
    instr = ins;
    n = (memWaits < 0) ? pickWaits() : 0;
    for (int k = 0; k <= n; k++) begin
      zero = 1'($urandom % 2);
      memReady = (k == n);
      e = idle(); e.mr = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
      if (k == n) begin e.irw = 1'b1; e.pcw = 1'b1; end
      applyStimulus(e, 1'b0, "fetch", 1'b0);
    end
    jitter();
    e = idle(); e.sa = 2'b01; e.sb = 2'b01; e.imm = immKind(op);
    applyStimulus(e, 1'b1, "decode", 1'b0);
    n = (memWaits < 0) ? pickWaits() : memWaits;
    if (!legalInstr(ins)) begin
      for (int k = 0; k < 10; k++) begin
        jitter();
        e = idle(); e.ill = 1'b1;
        applyStimulus(e, 1'b1, "halt", 1'b0);
      end
      applyReset();
    end else begin
      case (op)
        7'b0110011, 7'b0010011: begin
          jitter();
          e = idle(); e.sa = 2'b10; e.sb = (op == 7'b0010011) ? 2'b01 : 2'b00;
          e.alu = aluOp(f3, b30, op == 7'b0110011);
          applyStimulus(e, 1'b0, "execute", 1'b0);
          writeBack();
        end
        7'b0000011, 7'b0100011: begin
          jitter();
          e = idle(); e.sa = 2'b10; e.sb = 2'b01;
          applyStimulus(e, 1'b0, "mem-adr", 1'b0);
          if (op == 7'b0000011) begin
            memAccess(1'b0, n);
            jitter();
            e = idle(); e.rs = 2'b01; e.rw = 1'b1;
            applyStimulus(e, 1'b0, "mem-wb", 1'b0);
          end else if (resetInStore) begin
            memReady = 1'b0;
            e = idle(); e.adr = 1'b1; e.mw = 1'b1;
            applyStimulus(e, 1'b0, "store-stall", 1'b0);
            applyReset();
          end else begin
            memAccess(1'b1, n);
          end
        end
        7'b1100011: begin
          jitter();
          if (forceZero >= 0) zero = forceZero[0];
          equal = zero;
          less  = !zero;
          cond  = f3[2] ? less : equal;
          e = idle(); e.sa = 2'b10; e.pcw = cond ^ f3[0];
          e.alu = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
          applyStimulus(e, 1'b0, "branch", 1'b0);
        end
        7'b1101111: begin
          jitter();
          e = idle(); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
          applyStimulus(e, 1'b0, "jal", 1'b0);
          writeBack();
        end
        7'b1100111: begin
          jitter();
          e = idle(); e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
          applyStimulus(e, 1'b0, "jalr", 1'b0);
          jitter();
          e = idle(); e.sa = 2'b01; e.sb = 2'b10;
          applyStimulus(e, 1'b0, "jalr-link", 1'b0);
          writeBack();
        end
        default: begin
          jitter();
          e = idle(); e.sa = (op == 7'b0110111) ? 2'b11 : 2'b01; e.sb = 2'b01;
          applyStimulus(e, 1'b0, "upper-imm", 1'b0);
          writeBack();
        end
      endcase
    end
  endtask

  function automatic logic [31:0] genInstr();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom % 20;
    if (k < 4)        r[6:0] = 7'b0110011;
    else if (k < 8)   r[6:0] = 7'b0010011;
    else if (k < 10) begin
      r[6:0] = 7'b0000011;
      case ($urandom % 5) 0: r[14:12] = 3'd0; 1: r[14:12] = 3'd1; 2: r[14:12] = 3'd2;
                          3: r[14:12] = 3'd4; default: r[14:12] = 3'd5; endcase
    end
    else if (k < 12) begin r[6:0] = 7'b0100011; r[14:12] = 3'($urandom % 3); end
    else if (k < 15)  r[6:0] = 7'b1100011;
    else if (k == 15) r[6:0] = 7'b1101111;
    else if (k == 16) begin r[6:0] = 7'b1100111; r[14:12] = 3'd0; end
    else if (k == 17) r[6:0] = 7'b0110111;
    else if (k == 18) r[6:0] = 7'b0010111;
    else begin
      r[6:0] = 7'($urandom);
      if (r[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111}) r[6:0] = 7'b0001111;
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ctrlT e;
    rstN = 1'b0; rstN2 = 1'b0;
    instr = 32'h0; instr2 = 32'h0;
    zero = 1'b0; zero2 = 1'b0; memReady = 1'b1; memReady2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyReset();
    runInstr(32'h002081B3, 0, -1, 1'b0);
    runInstr(32'h40208133, 0, -1, 1'b0);
    runInstr(32'h4020D193, 0, -1, 1'b0);
    runInstr(32'h00208463, 0, 1, 1'b0);
    runInstr(32'h00209463, 0, 1, 1'b0);
    runInstr(32'h0000A283, 3, -1, 1'b0);
    runInstr(32'h0020A023, 0, -1, 1'b1);
    runInstr(32'h008000EF, 0, -1, 1'b0);
    runInstr(32'h000080E7, 0, -1, 1'b0);
    runInstr(32'h000012B7, 0, -1, 1'b0);
    runInstr(32'h00001297, 0, -1, 1'b0);
    runInstr(32'h00000000, 0, -1, 1'b0);
    repeat (250) runInstr(genInstr(), -1, -1, 1'b0);

    // Instance without handshake or trap: mem_ready stays low and an illegal word is a NOP
    rstN = 1'b0;
    rstN2 = 1'b1;
    applyStimulus(idle(), 1'b1, "boot", 1'b1);
    e = idle(); e.mr = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
    applyStimulus(e, 1'b0, "fetch", 1'b1);
    e = idle(); e.sa = 2'b01; e.sb = 2'b01;
    applyStimulus(e, 1'b1, "decode-illegal", 1'b1);
    e = idle(); e.mr = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
    applyStimulus(e, 1'b0, "fetch-after-nop", 1'b1);
    instr2 = 32'h0020A023;
    e = idle(); e.sa = 2'b01; e.sb = 2'b01; e.imm = 3'b001;
    applyStimulus(e, 1'b1, "decode-store", 1'b1);
    e = idle(); e.sa = 2'b10; e.sb = 2'b01;
    applyStimulus(e, 1'b0, "mem-adr", 1'b1);
    e = idle(); e.adr = 1'b1; e.mw = 1'b1;
    applyStimulus(e, 1'b0, "mem-write", 1'b1);
    e = idle(); e.mr = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
    applyStimulus(e, 1'b0, "fetch-after-store", 1'b1);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
